// File: rtl/seq_tx_if.sv
// Handshake and serial-line bundle between a pattern source and seq_tx.
// The master side requests transmissions and watches the line; the slave
// side (seq_tx) accepts requests and drives the serial output.
interface seq_tx_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4,
   parameter int GAP_W = 3
);
   // Request side
   logic             start;
   logic [WIDTH-1:0] pattern;
   logic [CNT_W-1:0] repeats;
   logic [GAP_W-1:0] gap;

   // Serial line and status
   logic             x;
   logic             valid;
   logic             busy;
   logic             done;

   modport master (
      output start, pattern, repeats, gap,
      input  x, valid, busy, done
   );

   modport slave (
      input  start, pattern, repeats, gap,
      output x, valid, busy, done
   );
endinterface : seq_tx_if

// File: rtl/seq_tx.sv
// Serial pattern transmitter. Latches a WIDTH-bit pattern on start and
// shifts it out MSB-first on x, one bit per clock, repeating it a
// programmable number of times with a programmable idle gap between
// repetitions. Every output is a register; nothing passes combinationally
// from the request inputs to the line.
module seq_tx #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4,
   parameter int GAP_W = 3
) (
   input logic    clk,
   input logic    reset,
   seq_tx_if.slave bus
);

   // Bit counter must be able to hold the value WIDTH itself.
   localparam int BIT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP,
      FIN
   } state_t;

   state_t           state_q, state_d;

   // Latched request; only these copies are used once a transfer starts.
   logic [WIDTH-1:0] pat_q,     pat_d;
   logic [CNT_W-1:0] rep_q,     rep_d;      // repetitions remaining, incl. current
   logic [GAP_W-1:0] gap_q,     gap_d;

   // Datapath counters.
   logic [WIDTH-1:0] shift_q,   shift_d;    // bits still to send, MSB next
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;  // bits already placed on x this repetition
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;  // idle cycles already spent in GAP

   // Registered outputs.
   logic             x_q,     x_d;
   logic             valid_q, valid_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;

   // Shared reload path: the first bit goes straight to x, the rest wait in
   // the shift register. Used on start accept, after a gap and back-to-back.
   logic             load_en;
   logic [WIDTH-1:0] load_src;

   // Next-state and next-output computation for every register.
   always_comb begin
      // NOTE: every _d signal gets a default before the case so that no path
      // leaves one unassigned, which would otherwise infer a latch.
      state_d   = state_q;
      pat_d     = pat_q;
      rep_d     = rep_q;
      gap_d     = gap_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      x_d       = x_q;
      valid_d   = valid_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      load_en   = 1'b0;
      load_src  = pat_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               pat_d = bus.pattern;
               rep_d = bus.repeats;
               gap_d = bus.gap;
               if (bus.repeats != '0) begin
                  load_en  = 1'b1;
                  load_src = bus.pattern;
               end else begin
                  // Nothing to send: report completion straight away.
                  state_d = FIN;
                  done_d  = 1'b1;
               end
            end
         end

         SHIFT: begin
            if (bit_cnt_q == BIT_W'(WIDTH)) begin
               // Last bit of this repetition has just been on the line.
               if (rep_q > CNT_W'(1)) begin
                  rep_d = rep_q - CNT_W'(1);
                  if (gap_q != '0) begin
                     state_d   = GAP;
                     gap_cnt_d = GAP_W'(1);
                     x_d       = 1'b0;
                     valid_d   = 1'b0;
                     busy_d    = 1'b1;
                  end else begin
                     // No gap: next repetition follows without a bubble.
                     load_en  = 1'b1;
                     load_src = pat_q;
                  end
               end else begin
                  state_d   = FIN;
                  rep_d     = '0;
                  bit_cnt_d = '0;
                  x_d       = 1'b0;
                  valid_d   = 1'b0;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
               end
            end else begin
               x_d       = shift_q[WIDTH-1];
               shift_d   = shift_q << 1;
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
         end

         GAP: begin
            if (gap_cnt_q == gap_q) begin
               gap_cnt_d = '0;
               load_en   = 1'b1;
               load_src  = pat_q;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end

         FIN: begin
            // start is deliberately not looked at here.
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            x_d     = 1'b0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase

      if (load_en) begin
         state_d   = SHIFT;
         x_d       = load_src[WIDTH-1];
         shift_d   = {load_src[WIDTH-2:0], 1'b0};
         bit_cnt_d = BIT_W'(1);
         valid_d   = 1'b1;
         busy_d    = 1'b1;
      end
   end

   // State, latched request, counters and outputs; asynchronous reset aborts
   // any transfer without producing done.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         pat_q     <= '0;
         rep_q     <= '0;
         gap_q     <= '0;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         x_q       <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples the
         // values computed for this edge, independent of statement order.
         state_q   <= state_d;
         pat_q     <= pat_d;
         rep_q     <= rep_d;
         gap_q     <= gap_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         x_q       <= x_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.x     = x_q;
   assign bus.valid = valid_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

endmodule : seq_tx
